// File: rtl/vga_token_scheduler.sv
// Token line owner for the VGA renderer: accepts keypad symbols one per cycle and
// expands signed calculator answers into '=', optional '-', and decimal digit tokens.
module vga_token_scheduler #(
  parameter int TOKENS = 200,
  parameter int TOK_W  = 4,
  parameter int ANS_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sym_valid,
  input  logic [TOK_W-1:0]          sym_data,
  output logic                      sym_ready,
  input  logic                      ans_valid,
  input  logic [ANS_W-1:0]          ans_data,
  output logic                      ans_ready,
  output logic [TOKENS*TOK_W-1:0]   token_to_vga,
  output logic                      busy,
  output logic                      overflow
);

  localparam int IDX_W = $clog2(TOKENS + 1);
  localparam int BCD_W = DIGITS * 4;

  localparam logic [TOK_W-1:0] TOK_EQ    = TOK_W'(4'hE);
  localparam logic [TOK_W-1:0] TOK_MINUS = TOK_W'(4'hB);
  localparam logic [TOK_W-1:0] TOK_CLEAR = TOK_W'(4'hF);

  typedef enum logic [2:0] {IDLE, EQ, SIGN, CONV, EMIT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               neg;
  logic [ANS_W-1:0]   mag;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [4:0]         cnt;
  logic               started;
  logic               wr_en, clear, ans_take;
  logic [TOK_W-1:0]   wr_data;
  logic [3:0]         digit;

  assign sym_ready = (state == IDLE);
  assign ans_ready = (state == IDLE) && !sym_valid;
  assign busy      = (state != IDLE);
  assign ans_take  = ans_valid && ans_ready;
  assign digit     = bcd[BCD_W-1 -: 4];

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sym_valid) begin
          if (sym_data == TOK_CLEAR) clear = 1'b1;
          else begin
            wr_en   = 1'b1;
            wr_data = sym_data;
          end
        end else if (ans_valid) begin
          state_nxt = EQ;
        end
      end
      EQ: begin
        wr_en     = 1'b1;
        wr_data   = TOK_EQ;
        state_nxt = neg ? SIGN : CONV;
      end
      SIGN: begin
        wr_en     = 1'b1;
        wr_data   = TOK_MINUS;
        state_nxt = CONV;
      end
      CONV: begin
        if (cnt == 5'(ANS_W - 1)) state_nxt = EMIT;
      end
      EMIT: begin
        // Leading zeros are suppressed, but the last digit always lands.
        if (digit != 4'd0 || started || cnt == 5'(DIGITS - 1)) begin
          wr_en   = 1'b1;
          wr_data = TOK_W'(digit);
        end
        if (cnt == 5'(DIGITS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_to_vga <= '0;
      idx          <= '0;
      overflow     <= 1'b0;
      neg          <= 1'b0;
      mag          <= '0;
      bcd          <= '0;
      cnt          <= '0;
      started      <= 1'b0;
    end else begin
      if (clear) begin
        token_to_vga <= '0;
        idx          <= '0;
        overflow     <= 1'b0;
      end else if (wr_en) begin
        // A full line drops the write and holds the index at TOKENS.
        if (idx == IDX_W'(TOKENS)) overflow <= 1'b1;
        else begin
          token_to_vga[idx*TOK_W +: TOK_W] <= wr_data;
          idx                              <= idx + IDX_W'(1);
        end
      end
      unique case (state)
        IDLE: begin
          if (ans_take) begin
            neg     <= ans_data[ANS_W-1];
            mag     <= ans_data[ANS_W-1] ? (~ans_data + ANS_W'(1)) : ans_data;
            bcd     <= '0;
            cnt     <= '0;
            started <= 1'b0;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], mag[ANS_W-1]};
          mag <= mag << 1;
          cnt <= cnt + 5'd1;
        end
        EMIT: begin
          bcd     <= bcd << 4;
          started <= started | (digit != 4'd0);
          cnt     <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
